cpu_param: RTL and testbench



---
 rtl/cpu_param.sv | 126 ++++++++++++
 tb/tb_cpu_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cpu_param.sv
// Two-register accumulator CPU with loadable program memory, zero/carry flags
// and an IDLE/RUN/HALTED sequencer. One instruction retires per RUN cycle.
//
// state  | meaning
// IDLE   | after reset, program memory writable, waiting for start
// RUN    | fetching and executing one instruction per cycle
// HALTED | HALT executed, program memory writable, start re-runs from 0
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W+3:0] prog_data,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_NOT, OP_SHL, OP_SHR, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HALT
    } opcode_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    logic [DATA_W-1:0] a, a_nxt, b, b_nxt;
    logic              zero, zero_nxt, carry, carry_nxt;
    logic              out_ld, upd_zero;
    logic [DATA_W+3:0] mem [DEPTH];
    logic [DATA_W+3:0] instr;
    opcode_t           opcode;
    logic [DATA_W-1:0] imm;

    assign instr  = mem[pc];
    assign opcode = opcode_t'(instr[DATA_W+3:DATA_W]);
    assign imm    = instr[DATA_W-1:0];
    assign pc_inc = pc + ADDR_W'(1);

    // Program memory has no reset so a loaded program survives a mid-run reset.
    always_ff @(posedge clk) begin
        if (prog_we && state != RUN)
            mem[prog_addr] <= prog_data;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        a_nxt     = a;
        b_nxt     = b;
        zero_nxt  = zero;
        carry_nxt = carry;
        out_ld    = 1'b0;
        upd_zero  = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    zero_nxt  = 1'b0;
                    carry_nxt = 1'b0;
                end
            end
            RUN: begin
                pc_nxt = pc_inc;
                case (opcode)
                    OP_NOP: ;
                    OP_LDA: begin a_nxt = imm; upd_zero = 1'b1; end
                    OP_LDB: b_nxt = imm;
                    OP_ADD: begin {carry_nxt, a_nxt} = {1'b0, a} + {1'b0, b}; upd_zero = 1'b1; end
                    OP_SUB: begin a_nxt = a - b; carry_nxt = (a < b); upd_zero = 1'b1; end
                    OP_AND: begin a_nxt = a & b; upd_zero = 1'b1; end
                    OP_OR:  begin a_nxt = a | b; upd_zero = 1'b1; end
                    OP_XOR: begin a_nxt = a ^ b; upd_zero = 1'b1; end
                    OP_NOT: begin a_nxt = ~a; upd_zero = 1'b1; end
                    OP_SHL: begin carry_nxt = a[DATA_W-1]; a_nxt = a << 1; upd_zero = 1'b1; end
                    OP_SHR: begin carry_nxt = a[0]; a_nxt = a >> 1; upd_zero = 1'b1; end
                    OP_JMP: pc_nxt = imm[ADDR_W-1:0];
                    OP_JZ:  if (zero)  pc_nxt = imm[ADDR_W-1:0];
                    OP_JC:  if (carry) pc_nxt = imm[ADDR_W-1:0];
                    OP_OUT: out_ld = 1'b1;
                    OP_HALT: begin pc_nxt = pc; state_nxt = HALTED; end
                    default: ;
                endcase
                if (upd_zero)
                    zero_nxt = (a_nxt == '0);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            a         <= '0;
            b         <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            zero      <= zero_nxt;
            carry     <= carry_nxt;
            out_valid <= out_ld;
            if (out_ld)
                data_out <= a;
        end
    end

    assign busy   = (state == RUN);
    assign halted = (state == HALTED);
    assign pc_out = pc;
endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: loads programs, runs them and compares every
// out_valid strobe against a queue of expected outputs.
module tb_cpu_param;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset, start, prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W+3:0] prog_data;
    logic [DATA_W-1:0] data_out;
    logic              out_valid, busy, halted;
    logic [ADDR_W-1:0] pc_out;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_val;

    cpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .data_out(data_out),
        .out_valid(out_valid), .busy(busy), .halted(halted), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_strobe: observed data_out=%0d, required no strobe", data_out);
            end
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                checks++;
                assert (int'(data_out) === exp_val) else begin
                    errors++;
                    $error("FAIL strobe_data: observed %0d, required %0d", data_out, exp_val);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, expv);
        end
    endtask

    task automatic load(input int addr, input logic [3:0] op, input int imm);
        @(posedge clk); #1;
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(addr);
        prog_data = {op, DATA_W'(imm)};
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int max_cyc, input int exp_pc);
        bit done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (halted) done = 1;
        end
        chk({tag, "_halted"}, int'(done), 1);
        chk({tag, "_pc"}, int'(pc_out), exp_pc);
        repeat (3) @(negedge clk);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        exp_q.delete();
    endtask

    task automatic load_countdown();
        load(0, 4'h1, 3); load(1, 4'h2, 1); load(2, 4'hE, 0); load(3, 4'h4, 0);
        load(4, 4'hC, 6); load(5, 4'hB, 2); load(6, 4'hE, 0); load(7, 4'hF, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_pc", int'(pc_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: 200 + 100 wraps to 44 with carry out
        load(0, 4'h1, 200); load(1, 4'h2, 100); load(2, 4'h3, 0);
        load(3, 4'hE, 0); load(4, 4'hF, 0);
        exp_q.push_back(44);
        pulse_start();
        chk("t1_busy", int'(busy), 1);
        wait_halt("t1", 50, 4);
        chk("t1_carry", int'(dut.carry), 1);
        chk("t1_data", int'(data_out), 44);

        // 6: reset in the second run cycle, data_out=44 still held from test 1
        pulse_start();
        chk("t6_data_kept", int'(data_out), 44);
        @(posedge clk); #1;
        chk("t6_pc_before", int'(pc_out), 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_halted", int'(halted), 0);
        chk("t6_pc", int'(pc_out), 0);
        chk("t6_data", int'(data_out), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_a", int'(dut.a), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(44);
        pulse_start();
        wait_halt("t6", 50, 4);

        // 2: 3 - 5 borrows, JC taken to the OUT at 5
        load(0, 4'h1, 3); load(1, 4'h2, 5); load(2, 4'h4, 0); load(3, 4'hD, 5);
        load(4, 4'hF, 0); load(5, 4'hE, 0); load(6, 4'hF, 0);
        exp_q.push_back(254);
        pulse_start();
        wait_halt("t2", 50, 6);
        chk("t2_carry", int'(dut.carry), 1);

        // 3: countdown loop
        load_countdown();
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        pulse_start();
        wait_halt("t3", 100, 7);

        // 4: pc wraps 15 -> 0, then JZ sees zero from LDA 0
        load(0, 4'hC, 5); load(1, 4'hB, 14); load(14, 4'h1, 0);
        load(15, 4'hE, 0); load(5, 4'hF, 0);
        exp_q.push_back(0);
        pulse_start();
        wait_halt("t4", 50, 5);

        // 5: write and start during RUN must both be ignored
        load_countdown();
        exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = ADDR_W'(7); prog_data = '0; start = 1'b1;
        @(posedge clk); #1;
        prog_we = 1'b0; start = 1'b0;
        wait_halt("t5", 100, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
